pad_output_arbiter: RTL

- Shares one output pad cell between NUM_REQ requesters (GPIO, peripheral outputs, debug) using round-robin request/grant.
- Drives the pad cell's pad_in_i, pad_oe_i and pad_attributes_i inputs. Sits between the pad ring and the peripheral muxing logic.
- Inserts a TURNAROUND window with output enable forced low on every ownership change, so two drivers never overlap on the pad.

---
 rtl/pad_output_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/pad_output_arbiter.sv
// pad_output_arbiter
//   Round-robin sharing of a single output pad cell between NUM_REQ requesters.
//   The owner's data/oe/attributes are passed combinationally to the pad cell.
//   Every ownership change is followed by a TURNAROUND-cycle window with the
//   output enable forced low, and then at least one IDLE cycle. This keeps the
//   drive windows of successive owners from overlapping on the pad.
//
// Ports
//   clk_i, rst_i      clock, asynchronous active-high reset
//   req_i             level requests (held high while ownership is wanted)
//   gnt_o             registered one-hot grant
//   data_i, oe_i      per-requester output value / output enable
//   attr_i            per-requester attributes, requester k at [k*PADATTR +: PADATTR]
//   pad_in_o          to pad cell pad_in_i
//   pad_oe_o          to pad cell pad_oe_i
//   pad_attributes_o  to pad cell pad_attributes_i
//   owner_o           current or most recent owner
//   busy_o            high while owned or in the turnaround window
module pad_output_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int PADATTR    = 16,
  parameter int TURNAROUND = 2,
  localparam int AW        = (PADATTR < 1) ? 1 : PADATTR,
  localparam int OW        = $clog2(NUM_REQ),
  parameter logic [AW-1:0] DEFAULT_ATTR = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NUM_REQ-1:0]    req_i,
  output logic [NUM_REQ-1:0]    gnt_o,
  input  logic [NUM_REQ-1:0]    data_i,
  input  logic [NUM_REQ-1:0]    oe_i,
  input  logic [NUM_REQ*AW-1:0] attr_i,
  output logic                  pad_in_o,
  output logic                  pad_oe_o,
  output logic [AW-1:0]         pad_attributes_o,
  output logic [OW-1:0]         owner_o,
  output logic                  busy_o
);

  localparam int CW = 4;

  typedef enum logic [1:0] {IDLE, OWNED, TURN} state_t;

  state_t                     state_q, state_d;
  logic [NUM_REQ-1:0]         gnt_q;
  logic [OW-1:0]              owner_q;
  logic [OW-1:0]              rr_ptr_q;
  logic [CW-1:0]              cnt_q;
  logic [AW-1:0]              attr_hold_q;
  logic [NUM_REQ-1:0][AW-1:0] attr_lane;
  logic [OW-1:0]              win;
  logic                       any_req;
  logic                       release_now;

  // Split the flat attribute bus into per-requester lanes.
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_lane
    assign attr_lane[k] = attr_i[k*AW +: AW];
  end

  // First set request searching upward from ptr, wrapping modulo NUM_REQ.
  function automatic logic [OW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                            input logic [OW-1:0] ptr);
    logic [OW-1:0] w;
    logic          found;
    int            c;
    w     = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      c = (int'(ptr) + i) % NUM_REQ;
      if (!found && req[c]) begin
        found = 1'b1;
        w     = OW'(c);
      end
    end
    return w;
  endfunction

  assign win         = rr_pick(req_i, rr_ptr_q);
  assign any_req     = |req_i;
  assign release_now = (state_q == OWNED) && !req_i[owner_q];

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (any_req) state_d = OWNED;
      OWNED:   if (release_now) state_d = (TURNAROUND > 0) ? TURN : IDLE;
      TURN:    if (cnt_q == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Grant, owner, round-robin pointer, turnaround counter, held attributes
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      gnt_q       <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      cnt_q       <= '0;
      attr_hold_q <= DEFAULT_ATTR;
    end else begin
      case (state_q)
        IDLE: if (any_req) begin
          gnt_q    <= NUM_REQ'(1) << win;
          owner_q  <= win;
          rr_ptr_q <= (win == OW'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        end
        OWNED: if (release_now) begin
          gnt_q       <= '0;
          // Freeze the owner's pull/drive settings so they stay put in TURN.
          attr_hold_q <= attr_lane[owner_q];
          cnt_q       <= CW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);
        end
        TURN: if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Output logic: pad signals follow the owner combinationally in OWNED.
  always_comb begin
    pad_in_o         = 1'b0;
    pad_oe_o         = 1'b0;
    pad_attributes_o = DEFAULT_ATTR;
    busy_o           = 1'b0;
    case (state_q)
      OWNED: begin
        pad_oe_o         = oe_i[owner_q];
        pad_in_o         = data_i[owner_q] & oe_i[owner_q];
        pad_attributes_o = attr_lane[owner_q];
        busy_o           = 1'b1;
      end
      TURN: begin
        pad_attributes_o = attr_hold_q;
        busy_o           = 1'b1;
      end
      default: ;
    endcase
  end

  assign gnt_o   = gnt_q;
  assign owner_o = owner_q;

endmodule
